// File: rtl/blink_seq_ctrl.sv
// rtl/blink_seq_ctrl.sv - status LED blink sequencer with shared tick prescaler (optional BLINK_REPEAT_EN)
module blink_seq_ctrl #(
   parameter int TICK_DIV  = 50000,
   parameter int ON_TICKS  = 250,
   parameter int OFF_TICKS = 250,
   parameter int GAP_TICKS = 1000,
   parameter int CNT_W     = 4,
   parameter int TW        = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [CNT_W-1:0] count_i,
   input  logic             abort_i,
`ifdef BLINK_REPEAT_EN
   input  logic             repeat_i,
`endif
   output logic             led_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             tick_o
);

   localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [TW-1:0] ON_LAST    = TW'(ON_TICKS - 1);
   localparam logic [TW-1:0] OFF_LAST   = TW'(OFF_TICKS - 1);
   localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_TICKS - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ON   = 2'd1;
   localparam logic [1:0] S_OFF  = 2'd2;
   localparam logic [1:0] S_GAP  = 2'd3;

   logic [PW-1:0]    presc_q, presc_d;
   logic [1:0]       state_q, state_d;
   logic [TW-1:0]    tcnt_q, tcnt_d;
   logic [CNT_W-1:0] remain_q, remain_d;
   logic             led_q, led_d;
   logic             done_q, done_d;
   logic             tick;
   logic             start_ok;
`ifdef BLINK_REPEAT_EN
   logic [CNT_W-1:0] count_lat_q, count_lat_d;
`endif

   assign tick     = (presc_q == PRESC_LAST);
   // abort beats a simultaneous start, so a start is only taken when abort is low
   assign start_ok = (state_q == S_IDLE) && start_i && !abort_i;

   // Prescaler free-runs; restarting it on an accepted start aligns the first phase to a full tick
   always_comb begin
      presc_d = presc_q + 1'b1;
      if (start_ok || tick) begin
         presc_d = '0;
      end
   end

   // Sequencer next-state: phases advance on the last tick of each phase, abort overrides all
   always_comb begin
      state_d  = state_q;
      remain_d = remain_q;
      done_d   = 1'b0;
`ifdef BLINK_REPEAT_EN
      count_lat_d = count_lat_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start_ok) begin
               if (count_i != '0) begin
                  state_d  = S_ON;
                  remain_d = count_i;
`ifdef BLINK_REPEAT_EN
                  count_lat_d = count_i;
`endif
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         S_ON: begin
            if (tick && (tcnt_q == ON_LAST)) begin
               remain_d = remain_q - 1'b1;
               state_d  = S_OFF;
            end
         end
         S_OFF: begin
            if (tick && (tcnt_q == OFF_LAST)) begin
               state_d = (remain_q != '0) ? S_ON : S_GAP;
            end
         end
         default: begin
            if (tick && (tcnt_q == GAP_LAST)) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
`ifdef BLINK_REPEAT_EN
               if (repeat_i) begin
                  state_d  = S_ON;
                  remain_d = count_lat_q;
               end
`endif
            end
         end
      endcase
      if ((state_q != S_IDLE) && abort_i) begin
         state_d = S_IDLE;
         done_d  = 1'b0;
      end
   end

   // Per-phase tick counter restarts whenever the phase changes
   always_comb begin
      tcnt_d = tcnt_q;
      if (state_d != state_q) begin
         tcnt_d = '0;
      end else if (tick) begin
         tcnt_d = tcnt_q + 1'b1;
      end
   end

   // LED follows the next state so it is registered yet lines up with the phase
   always_comb begin
      led_d = (state_d == S_ON);
   end

   // State registers with asynchronous reset
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         presc_q  <= '0;
         state_q  <= S_IDLE;
         tcnt_q   <= '0;
         remain_q <= '0;
         led_q    <= 1'b0;
         done_q   <= 1'b0;
`ifdef BLINK_REPEAT_EN
         count_lat_q <= '0;
`endif
      end else begin
         presc_q  <= presc_d;
         state_q  <= state_d;
         tcnt_q   <= tcnt_d;
         remain_q <= remain_d;
         led_q    <= led_d;
         done_q   <= done_d;
`ifdef BLINK_REPEAT_EN
         count_lat_q <= count_lat_d;
`endif
      end
   end

   assign led_o  = led_q;
   assign busy_o = (state_q != S_IDLE);
   assign done_o = done_q;
   assign tick_o = tick;

endmodule

// File: tb/tb_blink_seq_ctrl.sv
// tb/tb_blink_seq_ctrl.sv - scoreboard bench for blink_seq_ctrl
module tb_blink_seq_ctrl;

   localparam int DIV  = 4;
   localparam int ONT  = 2;
   localparam int OFFT = 3;
   localparam int GAPT = 5;
   localparam int P    = (ONT + OFFT) * DIV;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [3:0] count = 4'd0;
   logic       led, busy, done, tick;
`ifdef BLINK_REPEAT_EN
   logic       rpt = 1'b0;
`endif

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   // reference model state: active sequence start edge, blink count, prescaler restart edge
   bit act = 1'b0;
   int t0 = 0;
   int n = 0;
   int base = 0;
   int done_q[$];

   always #5 clk = ~clk;

   blink_seq_ctrl #(
      .TICK_DIV(DIV), .ON_TICKS(ONT), .OFF_TICKS(OFFT), .GAP_TICKS(GAPT), .CNT_W(4), .TW(16)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .start_i(start),
      .count_i(count),
      .abort_i(abort),
`ifdef BLINK_REPEAT_EN
      .repeat_i(rpt),
`endif
      .led_o(led),
      .busy_o(busy),
      .done_o(done),
      .tick_o(tick)
   );

   function automatic int seq_len(int k);
      return k * P + GAPT * DIV;
   endfunction

   task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, got, exp);
      end
   endtask

   // reference model: advances on each clock edge from the sampled inputs
   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         act = 1'b0;
         done_q.delete();
         base = cyc;
      end else if (act) begin
         if (abort) begin
            act = 1'b0;
            void'(done_q.pop_back());
         end else if (cyc - t0 == seq_len(n)) begin
            act = 1'b0;
         end
      end else if (start && !abort) begin
         base = cyc;
         if (count != 4'd0) begin
            act = 1'b1;
            t0 = cyc;
            n = int'(count);
            done_q.push_back(cyc + seq_len(n));
         end else begin
            done_q.push_back(cyc);
         end
      end
   end

   // monitor: compares outputs mid-cycle and retires expected done pulses
   always @(negedge clk) begin
      int t;
      bit el;
      if (rst) begin
         chk("rst_led", led, 0);
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         chk("rst_tick", tick, 0);
      end else begin
         el = 1'b0;
         if (act) begin
            t = cyc - t0 + 1;
            el = (t <= n * P) && (((t - 1) % P) < ONT * DIV);
         end
         chk("led", led, el);
         chk("busy", busy, act);
         chk("tick", tick, ((cyc - base) % DIV) == DIV - 1);
         while (done_q.size() > 0 && done_q[0] < cyc) begin
            chk("done_missed", 0, done_q.pop_front());
         end
         if (done) begin
            if (done_q.size() == 0) chk("done_unexpected", 1, 0);
            else chk("done_cycle", cyc, done_q.pop_front());
         end
      end
   end

   task automatic step(int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic go(logic [3:0] c);
      start = 1'b1;
      count = c;
      step(1);
      start = 1'b0;
   endtask

   initial begin
      int c;
      step(5);
      rst = 1'b0;
      step(12);
      // count 3, count input scrambled after latch
      go(4'd3);
      count = 4'($urandom);
      step(90);
      // count 0
      go(4'd0);
      step(6);
      // abort and start together in idle
      abort = 1'b1;
      go(4'd3);
      abort = 1'b0;
      step(6);
      // abort during second ON phase, then immediate restart
      go(4'd3);
      step(23);
      abort = 1'b1;
      step(1);
      abort = 1'b0;
      go(4'd2);
      step(70);
      // restart request while busy is ignored
      go(4'd3);
      step(29);
      start = 1'b1;
      count = 4'd9;
      step(3);
      start = 1'b0;
      count = 4'd1;
      step(60);
      // randomized sequences with stray starts, count changes and occasional aborts
      for (int it = 0; it < 10; it++) begin
         c = $urandom_range(0, 4);
         go(4'(c));
         for (int k = 0; k < seq_len(c) + 3; k++) begin
            start = ($urandom_range(0, 7) == 0);
            count = 4'($urandom);
            abort = (it % 3 == 2) && ($urandom_range(0, 59) == 0);
            step(1);
         end
         start = 1'b0;
         abort = 1'b0;
         step(3);
      end
      step(100);
      // asynchronous reset mid-sequence
      go(4'd2);
      step(15);
      #2 rst = 1'b1;
      step(2);
      rst = 1'b0;
      step(20);
      chk("done_pending", done_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
